// File: rtl/digit_frame_rx.sv
// Receiver/decoder for the 5-bit digit frame stream: edge-locked bit timing, MSB-first sampling, gap check.
// Define MAJORITY_VOTE_EN to take a 3-sample majority at each sample point (decode shifts +1 clk).
module digit_frame_rx #(
  parameter int BAUD_DIV = 500000,
  parameter int CNT_W    = $clog2(BAUD_DIV)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [4:0] data_out,
  output logic       data_valid,
  output logic       idle_sym,
  output logic       code_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [4:0]       FILL_CODE = 5'b11100;

  typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

  state_t           state_reg, state_next;
  logic             rx_meta_reg, rx_s, rx_d;
  logic [CNT_W-1:0] cnt_reg;
  logic [4:0]       shreg_reg;
  logic [1:0]       idx_reg;
  logic             start_edge;
  logic             cnt_zero;
  logic             tick;
  logic             bit_val;
  logic [4:0]       lut;
  logic             valid_next, idle_next, cerr_next, ferr_next;

  // {hit, digit} for the code table; hit=0 for anything outside the ten digits.
  function automatic logic [4:0] code_lookup(input logic [4:0] code);
    logic [4:0] r;
    r = 5'b0_0000;
    case (code)
      5'b10000: r = 5'b1_0000;
      5'b10001: r = 5'b1_0001;
      5'b10011: r = 5'b1_0010;
      5'b10010: r = 5'b1_0011;
      5'b10110: r = 5'b1_0100;
      5'b10111: r = 5'b1_0101;
      5'b10101: r = 5'b1_0110;
      5'b10100: r = 5'b1_0111;
      5'b11000: r = 5'b1_1000;
      5'b11001: r = 5'b1_1001;
      default:  r = 5'b0_0000;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b0;
      rx_s        <= 1'b0;
      rx_d        <= 1'b0;
    end else begin
      rx_meta_reg <= rx;
      rx_s        <= rx_meta_reg;
      rx_d        <= rx_s;
    end
  end

  assign start_edge = rx_s & ~rx_d;
  assign cnt_zero   = (cnt_reg == '0);

`ifdef MAJORITY_VOTE_EN
  logic vote_pend_reg, s_m1_reg, s_0_reg;

  // Samples at counter 1 and 0 are held; the third is the live rx_s one clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_pend_reg <= 1'b0;
      s_m1_reg      <= 1'b0;
      s_0_reg       <= 1'b0;
    end else begin
      vote_pend_reg <= (state_reg != IDLE) && cnt_zero;
      if ((state_reg != IDLE) && (cnt_reg == CNT_W'(1)))
        s_m1_reg <= rx_s;
      if ((state_reg != IDLE) && cnt_zero)
        s_0_reg <= rx_s;
    end
  end

  assign tick    = vote_pend_reg;
  assign bit_val = (s_m1_reg & s_0_reg) | (s_m1_reg & rx_s) | (s_0_reg & rx_s);
`else
  assign tick    = (state_reg != IDLE) && cnt_zero;
  assign bit_val = rx_s;
`endif

  // Bit timer free-runs through START/DATA/GAP; reload happens at nominal expiry either way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (start_edge)
        cnt_reg <= HALF_LOAD;
    end else if (cnt_zero) begin
      cnt_reg <= FULL_LOAD;
    end else begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start_edge) state_next = START;
      START: if (tick) state_next = bit_val ? DATA : IDLE;
      DATA:  if (tick && (idx_reg == 2'd0)) state_next = GAP;
      GAP:   if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_reg <= '0;
      idx_reg   <= '0;
    end else if (tick) begin
      if ((state_reg == START) && bit_val) begin
        shreg_reg <= 5'b10000;
        idx_reg   <= 2'd3;
      end else if (state_reg == DATA) begin
        shreg_reg[idx_reg] <= bit_val;
        idx_reg            <= idx_reg - 2'd1;
      end
    end
  end

  // Frame result, one pulse per accepted frame, gap error taking precedence.
  always_comb begin
    busy       = (state_reg != IDLE);
    lut        = code_lookup(shreg_reg);
    valid_next = 1'b0;
    idle_next  = 1'b0;
    cerr_next  = 1'b0;
    ferr_next  = 1'b0;
    if ((state_reg == GAP) && tick) begin
      if (bit_val)
        ferr_next = 1'b1;
      else if (lut[4])
        valid_next = 1'b1;
      else if (shreg_reg == FILL_CODE)
        idle_next = 1'b1;
      else
        cerr_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      idle_sym   <= 1'b0;
      code_err   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= valid_next;
      idle_sym   <= idle_next;
      code_err   <= cerr_next;
      frame_err  <= ferr_next;
      if (valid_next)
        data_out <= {1'b0, lut[3:0]};
    end
  end

endmodule
